// File: rtl/dlatch_bank.sv
// dlatch_bank: bank of CHANNELS independent WIDTH-bit capture registers.
// A channel loads d under en, then refuses further loads for HOLD cycles.
// Any refused request sets a sticky drop flag. Per-channel clear, global
// synchronous active-high reset.
// Optional feature: define DLATCH_BANK_TRANSPARENT_EN to let q follow d
// combinationally while a load is being accepted (latch-like transparency).
module dlatch_bank #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned HOLD     = 3
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [CHANNELS*WIDTH-1:0] d_i,
  input  logic [CHANNELS-1:0]       en_i,
  input  logic [CHANNELS-1:0]       clr_i,
  output logic [CHANNELS*WIDTH-1:0] q_o,
  output logic [CHANNELS-1:0]       busy_o,
  output logic [CHANNELS-1:0]       upd_o,
  output logic [CHANNELS-1:0]       drop_o
);

  // Counter must hold the value HOLD; keep at least one bit for HOLD = 0.
  localparam int unsigned CntW = (HOLD == 0) ? 1 : $clog2(HOLD + 1);
  localparam logic [CntW-1:0] HoldVal = CntW'(HOLD);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  typedef enum logic {StIdle, StHold} state_e;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    state_e            state_q;
    logic [CntW-1:0]   cnt_q;
    logic [WIDTH-1:0]  data_q;
    logic              upd_q;
    logic              drop_q;

    // Per-channel FSM: reset/clear beat load; a busy request only marks a drop.
    always_ff @(posedge clk_i) begin
      if (rst_i || clr_i[i]) begin
        state_q <= StIdle;
        cnt_q   <= '0;
        data_q  <= '0;
        upd_q   <= 1'b0;
        drop_q  <= 1'b0;
      end else if (en_i[i] && (state_q == StIdle)) begin
        data_q  <= d_i[i*WIDTH +: WIDTH];
        cnt_q   <= HoldVal;
        state_q <= (HOLD > 0) ? StHold : StIdle;
        upd_q   <= 1'b1;
      end else begin
        upd_q <= 1'b0;
        if (state_q == StHold) begin
          // Rejected requests still let the window run down.
          if (en_i[i]) begin
            drop_q <= 1'b1;
          end
          cnt_q <= cnt_q - CntOne;
          if (cnt_q == CntOne) begin
            state_q <= StIdle;
          end
        end
      end
    end

    assign busy_o[i] = (state_q == StHold);
    assign upd_o[i]  = upd_q;
    assign drop_o[i] = drop_q;

`ifdef DLATCH_BANK_TRANSPARENT_EN
    // Pass d straight through on the cycle a load would be accepted.
    assign q_o[i*WIDTH +: WIDTH] =
        (en_i[i] && (state_q == StIdle) && !clr_i[i] && !rst_i) ? d_i[i*WIDTH +: WIDTH]
                                                                : data_q;
`else
    assign q_o[i*WIDTH +: WIDTH] = data_q;
`endif
  end

endmodule

// File: tb/tb_dlatch_bank.sv
// Testbench for dlatch_bank: one instance with HOLD=3 and one with HOLD=0,
// both driven by the same stimulus and checked against a timestamp-based model.
module tb_dlatch_bank;

  localparam int W = 8;
  localparam int C = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [C*W-1:0] d;
  logic [C-1:0] en;
  logic [C-1:0] clr;

  logic [C*W-1:0] q_obs    [2];
  logic [C-1:0]   busy_obs [2];
  logic [C-1:0]   upd_obs  [2];
  logic [C-1:0]   drop_obs [2];

  int nerr = 0;
  int nchk = 0;

  always #5 clk = ~clk;

  dlatch_bank #(.WIDTH(W), .CHANNELS(C), .HOLD(3)) u_dut_h3 (
    .clk_i (clk), .rst_i (rst), .d_i (d), .en_i (en), .clr_i (clr),
    .q_o (q_obs[0]), .busy_o (busy_obs[0]), .upd_o (upd_obs[0]), .drop_o (drop_obs[0])
  );

  dlatch_bank #(.WIDTH(W), .CHANNELS(C), .HOLD(0)) u_dut_h0 (
    .clk_i (clk), .rst_i (rst), .d_i (d), .en_i (en), .clr_i (clr),
    .q_o (q_obs[1]), .busy_o (busy_obs[1]), .upd_o (upd_obs[1]), .drop_o (drop_obs[1])
  );

  // Model: each channel remembers the edge number of its last accepted load.
  int         hv [2] = '{3, 0};
  int         cur = 0;
  int         last  [2][C];
  logic [W-1:0] mq  [2][C];
  bit         mupd  [2][C];
  bit         mdrop [2][C];

  function automatic bit m_busy(int m, int c);
    return (cur - last[m][c]) < hv[m];
  endfunction

  task automatic model_edge();
    cur++;
    for (int m = 0; m < 2; m++) begin
      for (int c = 0; c < C; c++) begin
        if (rst || clr[c]) begin
          mq[m][c] = '0; last[m][c] = -1000; mupd[m][c] = 0; mdrop[m][c] = 0;
        end else if (en[c]) begin
          if (cur - last[m][c] > hv[m]) begin
            mq[m][c] = d[c*W +: W]; last[m][c] = cur; mupd[m][c] = 1;
          end else begin
            mdrop[m][c] = 1; mupd[m][c] = 0;
          end
        end else begin
          mupd[m][c] = 0;
        end
      end
    end
  endtask

  function automatic logic [C*W-1:0] exp_q(int m);
    logic [C*W-1:0] v;
    for (int c = 0; c < C; c++) begin
      v[c*W +: W] = mq[m][c];
`ifdef DLATCH_BANK_TRANSPARENT_EN
      if (en[c] && !m_busy(m, c) && !clr[c] && !rst) v[c*W +: W] = d[c*W +: W];
`endif
    end
    return v;
  endfunction

  function automatic logic [C-1:0] exp_busy(int m);
    logic [C-1:0] v;
    for (int c = 0; c < C; c++) v[c] = m_busy(m, c);
    return v;
  endfunction

  function automatic logic [C-1:0] exp_upd(int m);
    logic [C-1:0] v;
    for (int c = 0; c < C; c++) v[c] = mupd[m][c];
    return v;
  endfunction

  function automatic logic [C-1:0] exp_drop(int m);
    logic [C-1:0] v;
    for (int c = 0; c < C; c++) v[c] = mdrop[m][c];
    return v;
  endfunction

  // One rising edge; outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; en = '0; clr = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = '1; d = '1; clr = '0;
    tick();
    tick();
    for (int m = 0; m < 2; m++) begin
      nchk++; if (q_obs[m] !== '0) begin nerr++; $display("FAIL rst_q dut%0d got %h want 0", m, q_obs[m]); end
      nchk++; if (busy_obs[m] !== '0) begin nerr++; $display("FAIL rst_busy dut%0d got %b want 0", m, busy_obs[m]); end
      nchk++; if (upd_obs[m] !== '0) begin nerr++; $display("FAIL rst_upd dut%0d got %b want 0", m, upd_obs[m]); end
    end
    rst = 1'b0; en = '0;
    tick();
    for (int m = 0; m < 2; m++) begin
      nchk++; if (q_obs[m] !== '0) begin nerr++; $display("FAIL post_rst_q dut%0d got %h want 0", m, q_obs[m]); end
      nchk++; if (busy_obs[m] !== '0) begin nerr++; $display("FAIL post_rst_busy dut%0d got %b want 0", m, busy_obs[m]); end
      nchk++; if (upd_obs[m] !== '0) begin nerr++; $display("FAIL post_rst_upd dut%0d got %b want 0", m, upd_obs[m]); end
      nchk++; if (drop_obs[m] !== '0) begin nerr++; $display("FAIL post_rst_drop dut%0d got %b want 0", m, drop_obs[m]); end
    end
  endtask

  task automatic test_hold_window();
    apply_reset();
    d = '0; en = 4'b0001; d[7:0] = 8'hA5;        // edge 0
    tick();
    nchk++; if (q_obs[0][7:0] !== 8'hA5) begin nerr++; $display("FAIL hw_load_q got %h want a5", q_obs[0][7:0]); end
    nchk++; if (upd_obs[0][0] !== 1'b1) begin nerr++; $display("FAIL hw_upd_pulse got %b want 1", upd_obs[0][0]); end
    nchk++; if (busy_obs[0][0] !== 1'b1) begin nerr++; $display("FAIL hw_busy_e0 got %b want 1", busy_obs[0][0]); end
    en = '0;                                      // edge 1
    tick();
    nchk++; if (upd_obs[0][0] !== 1'b0) begin nerr++; $display("FAIL hw_upd_one_cycle got %b want 0", upd_obs[0][0]); end
    nchk++; if (busy_obs[0][0] !== 1'b1) begin nerr++; $display("FAIL hw_busy_e1 got %b want 1", busy_obs[0][0]); end
    en = 4'b0001; d[7:0] = 8'h3C;                 // edge 2: rejected
    tick();
    nchk++; if (q_obs[0][7:0] !== 8'hA5) begin nerr++; $display("FAIL hw_drop_q got %h want a5", q_obs[0][7:0]); end
    nchk++; if (drop_obs[0][0] !== 1'b1) begin nerr++; $display("FAIL hw_drop_flag got %b want 1", drop_obs[0][0]); end
    nchk++; if (busy_obs[0][0] !== 1'b1) begin nerr++; $display("FAIL hw_busy_e2 got %b want 1", busy_obs[0][0]); end
    en = '0;                                      // edge 3: window ends
    tick();
    nchk++; if (busy_obs[0][0] !== 1'b0) begin nerr++; $display("FAIL hw_busy_e3 got %b want 0", busy_obs[0][0]); end
    en = 4'b0001;                                 // edge 4: accepted again
    tick();
    nchk++; if (q_obs[0][7:0] !== 8'h3C) begin nerr++; $display("FAIL hw_reload_q got %h want 3c", q_obs[0][7:0]); end
    nchk++; if (upd_obs[0][0] !== 1'b1) begin nerr++; $display("FAIL hw_reload_upd got %b want 1", upd_obs[0][0]); end
    en = '0;
  endtask

  task automatic test_clear_priority();
    apply_reset();
    en = 4'b0010; d[15:8] = 8'h11;
    tick();
    clr = 4'b0010; en = 4'b0010; d[15:8] = 8'hFF;
    tick();
    nchk++; if (q_obs[0][15:8] !== 8'h00) begin nerr++; $display("FAIL clr_q got %h want 00", q_obs[0][15:8]); end
    nchk++; if (busy_obs[0][1] !== 1'b0) begin nerr++; $display("FAIL clr_busy got %b want 0", busy_obs[0][1]); end
    nchk++; if (drop_obs[0][1] !== 1'b0) begin nerr++; $display("FAIL clr_drop got %b want 0", drop_obs[0][1]); end
    nchk++; if (upd_obs[0][1] !== 1'b0) begin nerr++; $display("FAIL clr_upd got %b want 0", upd_obs[0][1]); end
    clr = '0; d[15:8] = 8'h22;
    tick();
    nchk++; if (q_obs[0][15:8] !== 8'h22) begin nerr++; $display("FAIL clr_reload_q got %h want 22", q_obs[0][15:8]); end
    nchk++; if (upd_obs[0][1] !== 1'b1) begin nerr++; $display("FAIL clr_reload_upd got %b want 1", upd_obs[0][1]); end
    en = '0;
  endtask

  task automatic test_independence();
    logic [C-1:0] want_upd;
    apply_reset();
    d = {8'h44, 8'h33, 8'h22, 8'h11}; en = '1;
    for (int j = 0; j < 12; j++) begin
      tick();
      want_upd = (j % 4 == 0) ? 4'hF : 4'h0;
      nchk++; if (upd_obs[0] !== want_upd) begin nerr++; $display("FAIL ind_upd j=%0d got %b want %b", j, upd_obs[0], want_upd); end
    end
    nchk++; if (drop_obs[0] !== 4'hF) begin nerr++; $display("FAIL ind_drop got %b want 1111", drop_obs[0]); end
    nchk++; if (q_obs[0] !== 32'h44332211) begin nerr++; $display("FAIL ind_q got %h want 44332211", q_obs[0]); end
    clr = 4'b0100;
    tick();
    clr = '0;
    nchk++; if (drop_obs[0] !== 4'b1011) begin nerr++; $display("FAIL ind_clr_drop got %b want 1011", drop_obs[0]); end
    nchk++; if (q_obs[0] !== 32'h44002211) begin nerr++; $display("FAIL ind_clr_q got %h want 44002211", q_obs[0]); end
    en = '0;
  endtask

  task automatic test_hold0();
    apply_reset();
    en = 4'b0001;
    for (int j = 0; j < 8; j++) begin
      d[7:0] = 8'(8'h10 + j);
      tick();
      nchk++; if (q_obs[1][7:0] !== 8'(8'h10 + j)) begin nerr++; $display("FAIL h0_q j=%0d got %h want %h", j, q_obs[1][7:0], 8'(8'h10 + j)); end
      nchk++; if (upd_obs[1][0] !== 1'b1) begin nerr++; $display("FAIL h0_upd j=%0d got %b want 1", j, upd_obs[1][0]); end
      nchk++; if (drop_obs[1][0] !== 1'b0 || busy_obs[1][0] !== 1'b0) begin nerr++; $display("FAIL h0_drop_busy j=%0d got %b%b want 00", j, drop_obs[1][0], busy_obs[1][0]); end
    end
    en = '0;
  endtask

  task automatic test_transparent();
    logic [W-1:0] want;
    apply_reset();
    en = 4'b0001; d[7:0] = 8'h5A;
    #1;
`ifdef DLATCH_BANK_TRANSPARENT_EN
    want = 8'h5A;
`else
    want = 8'h00;
`endif
    nchk++; if (q_obs[0][7:0] !== want) begin nerr++; $display("FAIL tr_idle_q got %h want %h", q_obs[0][7:0], want); end
    tick();
    d[7:0] = 8'hC3;
    #1;
    nchk++; if (q_obs[0][7:0] !== 8'h5A) begin nerr++; $display("FAIL tr_busy_q got %h want 5a", q_obs[0][7:0]); end
    en = '0;
  endtask

  task automatic test_random();
    apply_reset();
    for (int j = 0; j < 300; j++) begin
      rst = ($urandom_range(0, 59) == 0);
      for (int c = 0; c < C; c++) clr[c] = ($urandom_range(0, 15) == 0);
      en = C'($urandom);
      d  = $urandom;
      tick();
      for (int m = 0; m < 2; m++) begin
        nchk++; if (q_obs[m] !== exp_q(m)) begin nerr++; $display("FAIL rnd_q j=%0d dut%0d got %h want %h", j, m, q_obs[m], exp_q(m)); end
        nchk++; if (busy_obs[m] !== exp_busy(m)) begin nerr++; $display("FAIL rnd_busy j=%0d dut%0d got %b want %b", j, m, busy_obs[m], exp_busy(m)); end
        nchk++; if (upd_obs[m] !== exp_upd(m)) begin nerr++; $display("FAIL rnd_upd j=%0d dut%0d got %b want %b", j, m, upd_obs[m], exp_upd(m)); end
        nchk++; if (drop_obs[m] !== exp_drop(m)) begin nerr++; $display("FAIL rnd_drop j=%0d dut%0d got %b want %b", j, m, drop_obs[m], exp_drop(m)); end
      end
    end
    rst = 1'b0; clr = '0; en = '0;
  endtask

  initial begin
    for (int m = 0; m < 2; m++) begin
      for (int c = 0; c < C; c++) begin
        last[m][c] = -1000; mq[m][c] = '0; mupd[m][c] = 0; mdrop[m][c] = 0;
      end
    end
    rst = 1'b1; d = '0; en = '0; clr = '0;
    test_reset();
    test_hold_window();
    test_clear_priority();
    test_independence();
    test_hold0();
    test_transparent();
    test_random();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
